config_serial_rx: RTL

Asynchronous serial receiver that feeds the configuration manager control unit. It samples a UART-style line (1 start bit, 7 data bits LSB-first, even parity, 1 stop bit) and presents one byte per frame. The presentation consists of a one-cycle `fim_recepcao` pulse and a `paridade_ok` verdict, which the control unit consumes to step through TEMP1..TEMP4 and UMIDADE or to go to ERRO. Framing errors are folded into `paridade_ok`, so any bad frame drives the control unit into its error state.

---
 rtl/config_pkg.sv | 17 +
 rtl/serial_rx_tick.sv | 31 +++
 rtl/config_serial_rx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/config_pkg.sv
// Shared constants for the configuration receive path: state encoding,
// default bit timing and frame geometry.
package config_pkg;

  localparam logic [2:0] ST_IDLE           = 3'd0;
  localparam logic [2:0] ST_START          = 3'd1;
  localparam logic [2:0] ST_DATA           = 3'd2;
  localparam logic [2:0] ST_PARIDADE       = 3'd3;
  localparam logic [2:0] ST_STOP           = 3'd4;
  localparam logic [2:0] ST_FIM            = 3'd5;
  localparam logic [2:0] ST_ESPERA_REPOUSO = 3'd6;

  localparam int CLKS_PER_BIT_DEFAULT = 434;
  localparam int CONFIG_DATA_BITS     = 7;
  localparam int CONFIG_FRAME_COUNT   = 5;

endpackage

// File: rtl/serial_rx_tick.sv
// Bit-period timer: pulses tick after CLKS_PER_BIT/2 cycles (half) or
// CLKS_PER_BIT cycles, wrapping to 0 on every tick.
module serial_rx_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic half,
  output logic tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] FULL_LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF_LAST = W'(CLKS_PER_BIT / 2 - 1);

  logic [W-1:0] count;

  assign tick = ~clear & (count == (half ? HALF_LAST : FULL_LAST));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/config_serial_rx.sv
// UART-style receiver (start, DATA_BITS LSB-first, even parity, stop) that
// reports each frame with a one-cycle fim_recepcao and a combined verdict.
module config_serial_rx
  import config_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = CONFIG_DATA_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 habilita,
  output logic [DATA_BITS-1:0] dado,
  output logic                 fim_recepcao,
  output logic                 paridade_ok,
  output logic                 erro_stop,
  output logic                 ocupado
);

  typedef enum logic [2:0] {
    IDLE           = ST_IDLE,
    START          = ST_START,
    DATA           = ST_DATA,
    PARIDADE       = ST_PARIDADE,
    STOP           = ST_STOP,
    FIM            = ST_FIM,
    ESPERA_REPOUSO = ST_ESPERA_REPOUSO
  } state_t;

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  state_t               state;
  logic                 rx_meta, rx_s;
  logic [DATA_BITS-1:0] shift;
  logic [BW-1:0]        bit_cnt;
  logic                 parity_bit;
  logic                 tick, tick_clear, tick_half;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Timer runs only while a frame is being sampled.
  assign tick_clear = (state == IDLE) || (state == FIM) || (state == ESPERA_REPOUSO);
  assign tick_half  = (state == START);

  serial_rx_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (tick_clear),
    .half  (tick_half),
    .tick  (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shift        <= '0;
      bit_cnt      <= '0;
      parity_bit   <= 1'b0;
      dado         <= '0;
      fim_recepcao <= 1'b0;
      paridade_ok  <= 1'b0;
      erro_stop    <= 1'b0;
      ocupado      <= 1'b0;
    end else begin
      fim_recepcao <= 1'b0;
      case (state)
        IDLE: begin
          if (habilita && !rx_s) begin
            state   <= START;
            bit_cnt <= '0;
            ocupado <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (rx_s) begin
              state   <= IDLE;
              ocupado <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) state <= PARIDADE;
            else bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARIDADE: begin
          if (tick) begin
            parity_bit <= rx_s;
            state      <= STOP;
          end
        end
        STOP: begin
          // Outputs land together with the FIM state so the pulse and FIM coincide.
          if (tick) begin
            dado         <= shift;
            erro_stop    <= ~rx_s;
            paridade_ok  <= ~(^shift ^ parity_bit) & rx_s;
            fim_recepcao <= 1'b1;
            state        <= FIM;
          end
        end
        FIM: begin
          if (erro_stop) begin
            state <= ESPERA_REPOUSO;
          end else begin
            state   <= IDLE;
            ocupado <= 1'b0;
          end
        end
        ESPERA_REPOUSO: begin
          if (rx_s) begin
            state   <= IDLE;
            ocupado <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule
